// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave for the multicycle core's control FSM.
// Captures a single-cycle MemRead/MemWrite request, waits LATENCY cycles, then
// performs the access on an internal word-organised RAM and pulses MemReady.
//
// Parameters:
//   AW       byte-address width; the RAM holds 2^(AW-2) 32-bit words
//   LATENCY  cycles from request acceptance to MemReady (1..15)
// Ports:
//   CLK, RST           clock (rising edge), synchronous active-high reset
//   MemRead/MemWrite   request strobes, sampled when not BUSY
//   BE                 access size: 0001 byte, 0011 half, 1111 word
//   funct3             load/store funct3, selects load extension
//   ADDR               byte address
//   WDATA              right-aligned store data
//   RDATA              extended load data, valid with MemReady, then held
//   MemReady           one-cycle completion pulse
//   BUSY               high while a request is waiting out its latency
//   ERR                one-cycle pulse alongside MemReady for illegal requests
// Optional feature macro:
//   DMEM_MISALIGN_CHK_EN  reject misaligned half/word accesses (no write, RDATA=0)

module dmem_responder #(
  parameter int unsigned AW      = 12,
  parameter int unsigned LATENCY = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic [3:0]    BE,
  input  logic [2:0]    funct3,
  input  logic [AW-1:0] ADDR,
  input  logic [31:0]   WDATA,
  output logic [31:0]   RDATA,
  output logic          MemReady,
  output logic          BUSY,
  output logic          ERR
);

  localparam int unsigned Depth = 2 ** (AW - 2);
  localparam logic [3:0]  LatM1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Captured request
  logic [AW-1:0] addr_q;
  logic [3:0]    be_q;
  logic [2:0]    f3_q;
  logic [31:0]   wdata_q;
  logic          is_load_q;
  logic          is_store_q;
  logic          illegal_q;

  logic [31:0] rdata_q;
  logic [31:0] mem [Depth];

  logic        req;
  logic        accept;
  logic [1:0]  off;
  logic [4:0]  sh_amt;
  logic [31:0] word;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic        f3_bad;
  logic        misalign;
  logic [3:0]  lanes;
  logic [31:0] wdata_sh;
  logic        in_resp;
  logic        rdata_upd;
  logic [31:0] rdata_new;
  logic        err_resp;

  assign req = MemRead | MemWrite;
  // RESP also accepts, which gives back-to-back issue on the MemReady edge.
  assign accept = req && (state_q != StWait);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StResp: begin
        if (accept) begin
          cnt_d   = LatM1;
          state_d = (LATENCY == 1) ? StResp : StWait;
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StResp;
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST && accept) begin
      addr_q     <= ADDR;
      be_q       <= BE;
      f3_q       <= funct3;
      wdata_q    <= WDATA;
      is_load_q  <= MemRead & ~MemWrite;
      is_store_q <= MemWrite & ~MemRead;
      illegal_q  <= MemRead & MemWrite;
    end
  end

  // ---------------------------------------------------------------------------
  // Access datapath
  // ---------------------------------------------------------------------------
  assign off      = addr_q[1:0];
  assign sh_amt   = {off, 3'b000};
  assign word     = mem[addr_q[AW-1:2]];
  assign shifted  = word >> sh_amt;
  // Lanes pushed past byte 3 fall off the 4-bit result.
  assign lanes    = be_q << off;
  assign wdata_sh = wdata_q << sh_amt;

`ifdef DMEM_MISALIGN_CHK_EN
  assign misalign = ~illegal_q &&
                    (((be_q == 4'b0011) && addr_q[0]) ||
                     ((be_q == 4'b1111) && (off != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    f3_bad   = 1'b0;
    load_val = word;
    unique case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      3'b010:  load_val = shifted;
      default: begin
        load_val = word;
        f3_bad   = 1'b1;
      end
    endcase
  end

  assign in_resp   = (state_q == StResp);
  assign rdata_upd = in_resp && (is_load_q || misalign);
  assign rdata_new = misalign ? 32'd0 : load_val;
  assign err_resp  = illegal_q || (is_load_q && f3_bad) || misalign;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rdata_q <= 32'd0;
    end else if (rdata_upd) begin
      rdata_q <= rdata_new;
    end
  end

  // RAM is not reset; a reset during RESP suppresses the write.
  always_ff @(posedge CLK) begin
    if (!RST && in_resp && is_store_q && !misalign) begin
      for (int i = 0; i < 4; i++) begin
        if (lanes[i]) mem[addr_q[AW-1:2]][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    MemReady = in_resp;
    BUSY     = (state_q == StWait);
    ERR      = in_resp && err_resp;
    RDATA    = rdata_upd ? rdata_new : rdata_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: byte-array reference model,
// expected-response queue, and a monitor that checks every MemReady pulse.

module tb_dmem_responder;

  localparam int unsigned AW  = 12;
  localparam int unsigned LAT = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          MemRead;
  logic          MemWrite;
  logic [3:0]    BE;
  logic [2:0]    funct3;
  logic [AW-1:0] ADDR;
  logic [31:0]   WDATA;
  logic [31:0]   RDATA;
  logic          MemReady;
  logic          BUSY;
  logic          ERR;

  always #5 CLK = ~CLK;

  dmem_responder #(.AW(AW), .LATENCY(LAT)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .MemRead (MemRead),
    .MemWrite(MemWrite),
    .BE      (BE),
    .funct3  (funct3),
    .ADDR    (ADDR),
    .WDATA   (WDATA),
    .RDATA   (RDATA),
    .MemReady(MemReady),
    .BUSY    (BUSY),
    .ERR     (ERR)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mm [256];
  logic [31:0] last_rd;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input int a);
    int b;
    b = a & ~3;
    return {mm[b+3], mm[b+2], mm[b+1], mm[b]};
  endfunction

  function automatic bit misaligned(input logic [3:0] be, input int a);
`ifdef DMEM_MISALIGN_CHK_EN
    return ((be == 4'b0011) && (a % 2 != 0)) || ((be == 4'b1111) && (a % 4 != 0));
`else
    return 1'b0;
`endif
  endfunction

  // Compute the expected response, update the model, issue the request and
  // wait for MemReady. Returns at the negedge inside the RESP cycle.
  task automatic req(input bit rd, input bit wr, input logic [3:0] be, input logic [2:0] f3,
                     input int a, input logic [31:0] wd, input bit inject_busy);
    exp_t        e;
    int          off;
    int          lat;
    logic [31:0] w;
    logic [31:0] s;
    logic [31:0] v;
    bit          mis;
    off   = a % 4;
    mis   = !(rd && wr) && misaligned(be, a);
    e.err = (rd && wr) || mis;
    if (rd && wr) begin
      e.rdata = last_rd;
    end else if (mis) begin
      last_rd = 32'd0;
      e.rdata = 32'd0;
    end else if (wr) begin
      for (int i = 0; i < 4; i++)
        if (be[i] && (off + i < 4)) mm[a+i] = wd[8*i +: 8];
      e.rdata = last_rd;
    end else begin
      w = word_at(a);
      s = w >> (8 * off);
      case (f3)
        3'b000:  v = {{24{s[7]}}, s[7:0]};
        3'b100:  v = {24'd0, s[7:0]};
        3'b001:  v = {{16{s[15]}}, s[15:0]};
        3'b101:  v = {16'd0, s[15:0]};
        3'b010:  v = s;
        default: begin
          v     = w;
          e.err = 1'b1;
        end
      endcase
      last_rd = v;
      e.rdata = v;
    end
    exp_q.push_back(e);
    MemRead  = rd;
    MemWrite = wr;
    BE       = be;
    funct3   = f3;
    ADDR     = AW'(a);
    WDATA    = wd;
    @(posedge CLK);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (MemReady === 1'b1) begin
        lat = k;
        break;
      end
      if (inject_busy && k == 1) begin
        check("busy_high", {31'd0, BUSY}, 32'd1);
        MemRead = 1'b1;
        @(posedge CLK);
        #1;
        MemRead = 1'b0;
      end
    end
    check("latency", lat, LAT);
  endtask

  // Monitor: every MemReady must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (MemReady === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ready: got MemReady=1 expected no response at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("rdata", RDATA, e.rdata);
        check("err", {31'd0, ERR}, {31'd0, e.err});
        check("busy_at_ready", {31'd0, BUSY}, 32'd0);
      end
    end else if (RST === 1'b0) begin
      check("err_idle", {31'd0, ERR}, 32'd0);
    end
  end

  initial begin
    logic [3:0]  be_tab [3];
    logic [2:0]  f3_tab [5];
    logic [2:0]  bad_tab [3];
    be_tab  = '{4'b0001, 4'b0011, 4'b1111};
    f3_tab  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    bad_tab = '{3'b011, 3'b110, 3'b111};
    last_rd  = 32'd0;
    RST      = 1'b1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    BE       = 4'b0;
    funct3   = 3'b0;
    ADDR     = '0;
    WDATA    = 32'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_rdata", RDATA, 32'd0);
    check("reset_ready", {31'd0, MemReady}, 32'd0);
    check("reset_busy", {31'd0, BUSY}, 32'd0);
    check("reset_err", {31'd0, ERR}, 32'd0);
    RST = 1'b0;

    // Fill the modelled region so no load ever sees uninitialised RAM.
    for (int w = 0; w < 64; w++) req(0, 1, 4'b1111, 3'b010, 4 * w, $urandom, 0);

    // Word store/load
    req(0, 1, 4'b1111, 3'b010, 'h010, 32'hDEADBEEF, 0);
    req(1, 0, 4'b1111, 3'b010, 'h010, 32'd0, 0);
    // Byte extension
    req(0, 1, 4'b1111, 3'b010, 'h020, 32'd0, 0);
    req(0, 1, 4'b0001, 3'b000, 'h021, 32'h00000080, 0);
    req(1, 0, 4'b0001, 3'b000, 'h021, 32'd0, 0);
    req(1, 0, 4'b0001, 3'b100, 'h021, 32'd0, 0);
    req(1, 0, 4'b1111, 3'b010, 'h020, 32'd0, 0);
    // Half extension
    req(0, 1, 4'b1111, 3'b010, 'h030, 32'd0, 0);
    req(0, 1, 4'b0011, 3'b001, 'h032, 32'h00008001, 0);
    req(1, 0, 4'b0011, 3'b001, 'h032, 32'd0, 0);
    req(1, 0, 4'b0011, 3'b101, 'h032, 32'd0, 0);
    req(1, 0, 4'b1111, 3'b010, 'h030, 32'd0, 0);
    // Request while busy is dropped
    req(1, 0, 4'b1111, 3'b010, 'h010, 32'd0, 1);
    repeat (4) @(negedge CLK);
    // Simultaneous read/write is illegal and leaves memory alone
    req(1, 1, 4'b1111, 3'b010, 'h010, 32'h12345678, 0);
    req(1, 0, 4'b1111, 3'b010, 'h010, 32'd0, 0);
    // Unknown load funct3 returns the raw word with ERR
    req(1, 0, 4'b1111, 3'b011, 'h010, 32'd0, 0);

    // Reset during WAIT of a store aborts it
    MemWrite = 1'b1;
    BE       = 4'b1111;
    funct3   = 3'b010;
    ADDR     = AW'('h040);
    WDATA    = 32'h11111111;
    @(posedge CLK);
    #1;
    MemWrite = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("abort_busy", {31'd0, BUSY}, 32'd0);
    check("abort_ready", {31'd0, MemReady}, 32'd0);
    check("abort_rdata", RDATA, 32'd0);
    last_rd = 32'd0;
    req(1, 0, 4'b1111, 3'b010, 'h040, 32'd0, 0);
    // Misaligned word load
    req(1, 0, 4'b1111, 3'b010, 'h042, 32'd0, 0);

    // Randomised traffic
    for (int n = 0; n < 250; n++) begin
      int          kind;
      int          a;
      logic [3:0]  be;
      kind = $urandom_range(0, 19);
      a    = $urandom_range(0, 255);
      be   = be_tab[$urandom_range(0, 2)];
      if (kind < 8)       req(0, 1, be, 3'b010, a, $urandom, 0);
      else if (kind < 17) req(1, 0, be, f3_tab[$urandom_range(0, 4)], a, 32'd0, 0);
      else if (kind < 19) req(1, 0, 4'b1111, bad_tab[$urandom_range(0, 2)], a & ~3, 32'd0, 0);
      else                req(1, 1, be, 3'b010, a, $urandom, 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
    end

    repeat (5) @(negedge CLK);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
